// File: rtl/uart_mmio_ctrl_if.sv
// Bus and UART-side signals of the UART MMIO controller.
// The controller takes the slave view; the CPU/bus side and the UART cores take the master view.
interface uart_mmio_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            Device_sel;
    logic                  Mem_Write_i;
    logic                  Mem_Read_i;
    logic [DATA_WIDTH-1:0] Write_Data_i;
    logic [DATA_WIDTH-1:0] Read_Data_o;
    logic [7:0]            Tx_Data_o;
    logic                  Tx_Start_o;
    logic                  Tx_Busy_i;
    logic [7:0]            Rx_Data_i;
    logic                  Rx_Valid_i;
    logic                  Irq_o;

    modport slave (
        input  Device_sel, Mem_Write_i, Mem_Read_i, Write_Data_i,
        input  Tx_Busy_i, Rx_Data_i, Rx_Valid_i,
        output Read_Data_o, Tx_Data_o, Tx_Start_o, Irq_o
    );

    modport master (
        output Device_sel, Mem_Write_i, Mem_Read_i, Write_Data_i,
        output Tx_Busy_i, Rx_Data_i, Rx_Valid_i,
        input  Read_Data_o, Tx_Data_o, Tx_Start_o, Irq_o
    );
endinterface

// File: rtl/uart_mmio_ctrl.sv
// UART MMIO controller: TX byte FIFO with launch sequencer, RX holding register,
// control/status register and level interrupt.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing in flight; leaves as soon as the FIFO holds a byte
// LOAD    | FIFO head copied to Tx_Data_o and popped
// START   | Tx_Start_o high for this single cycle
// WAIT_HI | waiting for the transmitter to report busy (16-cycle timeout)
// WAIT_LO | waiting for the transmitter to finish the byte
module uart_mmio_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic            clk,
    input  logic            rst,
    uart_mmio_ctrl_if.slave bus
);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO} state_t;

    state_t             state;
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [3:0]         timer;
    logic [7:0]         rx_hold;
    logic               rx_valid;
    logic               overrun;
    logic               tx_drop;
    logic               irq_en;

    logic               tx_wr, ctrl_wr, rx_rd;
    logic               fifo_empty, fifo_full;
    logic               push, pop, flush, timeout, busy;
    logic [11:0]        status;
    logic [DATA_WIDTH-1:0] rd_next;

    // Access decode and FIFO/status flags.
    always_comb begin
        tx_wr      = (bus.Device_sel == 2'b01) && bus.Mem_Write_i;
        ctrl_wr    = (bus.Device_sel == 2'b11) && bus.Mem_Write_i;
        rx_rd      = (bus.Device_sel == 2'b10) && bus.Mem_Read_i;
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        push       = tx_wr && !fifo_full;
        pop        = (state == LOAD) && !fifo_empty;
        flush      = ctrl_wr && bus.Write_Data_i[0];
        timeout    = (state == WAIT_HI) && !bus.Tx_Busy_i && (timer == 4'd0);
        busy       = (state != IDLE) || !fifo_empty;
        status     = {4'(count), irq_en, tx_drop, overrun, rx_valid,
                      busy, fifo_full, fifo_empty, 1'b0};
    end

    // Read mux; unmapped and TX-data reads return zero.
    always_comb begin
        rd_next = '0;
        case (bus.Device_sel)
            2'b10:   rd_next[7:0]  = rx_hold;
            2'b11:   rd_next[11:0] = status;
            default: rd_next       = '0;
        endcase
    end

    // TX FIFO storage, pointers and occupancy; flush overrides push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.Write_Data_i[7:0];
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // TX launch sequencer. A flush racing the IDLE->LOAD transition leaves LOAD
    // with an empty FIFO, in which case nothing is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.Tx_Data_o  <= '0;
            bus.Tx_Start_o <= 1'b0;
            timer          <= '0;
        end else begin
            bus.Tx_Start_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) state <= LOAD;
                end
                LOAD: begin
                    if (!fifo_empty) begin
                        bus.Tx_Data_o  <= fifo_mem[rd_ptr];
                        bus.Tx_Start_o <= 1'b1;
                        state          <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    timer <= 4'd15;
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (bus.Tx_Busy_i)        state <= WAIT_LO;
                    else if (timer == 4'd0)   state <= IDLE;
                    else                      timer <= timer - 4'd1;
                end
                WAIT_LO: begin
                    if (!bus.Tx_Busy_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RX holding register, sticky error flags, irq enable, interrupt and read data.
    // Within a cycle, a new error event wins over a software clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_hold         <= '0;
            rx_valid        <= 1'b0;
            overrun         <= 1'b0;
            tx_drop         <= 1'b0;
            irq_en          <= 1'b0;
            bus.Irq_o       <= 1'b0;
            bus.Read_Data_o <= '0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= bus.Write_Data_i[2];
                if (bus.Write_Data_i[1]) begin
                    overrun <= 1'b0;
                    tx_drop <= 1'b0;
                end
            end
            if ((tx_wr && fifo_full) || timeout) tx_drop <= 1'b1;
            if (bus.Rx_Valid_i) begin
                rx_hold  <= bus.Rx_Data_i;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_rd) overrun <= 1'b1;
            end else if (rx_rd) begin
                rx_valid <= 1'b0;
            end
            bus.Irq_o <= irq_en && (rx_valid || (fifo_empty && state == IDLE));
            if (bus.Mem_Read_i) bus.Read_Data_o <= rd_next;
        end
    end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: register/RX vector table plus TX sequences
// driven against a small behavioural transmitter.
module tb_uart_mmio_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    // 0: transmitter model, 1: busy stuck high, 2: busy stuck low
    int         tx_mode = 2;
    int         start_cnt = 0;
    int         dbl_pulse = 0;
    logic [7:0] tx_log [$];

    uart_mmio_ctrl_if #(.DATA_WIDTH(32)) bus ();

    uart_mmio_ctrl #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .PTR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic        wr;
        logic        rd;
        logic [31:0] wdata;
        logic        rxv;
        logic [7:0]  rxd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic [1:0] sel, input logic wr, input logic rd,
                                input logic [31:0] wdata, input logic rxv,
                                input logic [7:0] rxd, input logic chk,
                                input logic [31:0] exp);
        vec_t v;
        v.sel = sel; v.wr = wr; v.rd = rd; v.wdata = wdata;
        v.rxv = rxv; v.rxd = rxd; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.Device_sel   = 2'b00;
        bus.Mem_Write_i  = 1'b0;
        bus.Mem_Read_i   = 1'b0;
        bus.Write_Data_i = '0;
        bus.Rx_Valid_i   = 1'b0;
        bus.Rx_Data_i    = '0;
    endtask

    task automatic bus_write(input logic [1:0] sel, input logic [31:0] data);
        bus.Device_sel   = sel;
        bus.Mem_Write_i  = 1'b1;
        bus.Write_Data_i = data;
        cyc();
        idle_bus();
    endtask

    task automatic bus_read(input logic [1:0] sel);
        bus.Device_sel = sel;
        bus.Mem_Read_i = 1'b1;
        cyc();
        idle_bus();
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    // Transmitter model and Tx_Start_o monitor; sole driver of Tx_Busy_i.
    initial begin : tx_model
        int   dly;
        int   hold;
        logic prev_start;
        dly = 0; hold = 0; prev_start = 1'b0;
        bus.Tx_Busy_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.Tx_Start_o === 1'b1) begin
                if (prev_start) dbl_pulse++;
                tx_log.push_back(bus.Tx_Data_o);
                start_cnt++;
                dly = 2;
            end
            prev_start = (bus.Tx_Start_o === 1'b1);
            case (tx_mode)
                1: bus.Tx_Busy_i = 1'b1;
                2: bus.Tx_Busy_i = 1'b0;
                default: begin
                    if (dly > 0) begin
                        dly--;
                        if (dly == 0) begin
                            bus.Tx_Busy_i = 1'b1;
                            hold = 10;
                        end
                    end else if (hold > 0) begin
                        hold--;
                        if (hold == 0) bus.Tx_Busy_i = 1'b0;
                    end
                end
            endcase
        end
    end

    initial begin : main
        int n0;
        idle_bus();

        // RX path, status register, unmapped reads and irq enable bit.
        vecs[0]  = mk(2'b11, 0, 1, 32'h0,  0, 8'h00, 1, 32'h0000_0002);
        vecs[1]  = mk(2'b00, 0, 0, 32'h0,  1, 8'h5A, 0, 32'h0);
        vecs[2]  = mk(2'b10, 0, 1, 32'h0,  0, 8'h00, 1, 32'h0000_005A);
        vecs[3]  = mk(2'b11, 0, 1, 32'h0,  0, 8'h00, 1, 32'h0000_0002);
        vecs[4]  = mk(2'b00, 0, 0, 32'h0,  1, 8'h11, 0, 32'h0);
        vecs[5]  = mk(2'b00, 0, 0, 32'h0,  1, 8'h22, 0, 32'h0);
        vecs[6]  = mk(2'b11, 0, 1, 32'h0,  0, 8'h00, 1, 32'h0000_0032);
        vecs[7]  = mk(2'b10, 0, 1, 32'h0,  0, 8'h00, 1, 32'h0000_0022);
        vecs[8]  = mk(2'b11, 1, 0, 32'h2,  0, 8'h00, 0, 32'h0);
        vecs[9]  = mk(2'b11, 0, 1, 32'h0,  0, 8'h00, 1, 32'h0000_0002);
        vecs[10] = mk(2'b00, 0, 0, 32'h0,  1, 8'h44, 0, 32'h0);
        vecs[11] = mk(2'b10, 0, 1, 32'h0,  1, 8'h33, 1, 32'h0000_0044);
        vecs[12] = mk(2'b11, 0, 1, 32'h0,  0, 8'h00, 1, 32'h0000_0012);
        vecs[13] = mk(2'b10, 0, 1, 32'h0,  0, 8'h00, 1, 32'h0000_0033);
        vecs[14] = mk(2'b00, 0, 1, 32'h0,  0, 8'h00, 1, 32'h0000_0000);
        vecs[15] = mk(2'b01, 0, 1, 32'h0,  0, 8'h00, 1, 32'h0000_0000);
        vecs[16] = mk(2'b11, 0, 1, 32'h0,  0, 8'h00, 1, 32'h0000_0002);
        vecs[17] = mk(2'b11, 1, 0, 32'h4,  0, 8'h00, 0, 32'h0);
        vecs[18] = mk(2'b11, 0, 1, 32'h0,  0, 8'h00, 1, 32'h0000_0082);
        vecs[19] = mk(2'b11, 1, 0, 32'h0,  0, 8'h00, 0, 32'h0);
        vecs[20] = mk(2'b11, 0, 1, 32'h0,  0, 8'h00, 1, 32'h0000_0002);

        // Reset
        rst = 1'b1;
        cyc();
        cyc();
        check("reset_read_data", bus.Read_Data_o, 32'h0);
        check("reset_tx_data",   32'(bus.Tx_Data_o), 32'h0);
        check("reset_tx_start",  32'(bus.Tx_Start_o), 32'h0);
        check("reset_irq",       32'(bus.Irq_o), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            bus.Device_sel   = vecs[i].sel;
            bus.Mem_Write_i  = vecs[i].wr;
            bus.Mem_Read_i   = vecs[i].rd;
            bus.Write_Data_i = vecs[i].wdata;
            bus.Rx_Valid_i   = vecs[i].rxv;
            bus.Rx_Data_i    = vecs[i].rxd;
            cyc();
            idle_bus();
            if (vecs[i].chk) check($sformatf("vec%0d_read", i), bus.Read_Data_o, vecs[i].exp);
        end
        check("no_start_after_reg_tests", 32'(start_cnt), 32'd0);

        // Two bytes through the transmitter model; upper data bits ignored.
        tx_mode = 0;
        bus_write(2'b01, 32'h0000_0041);
        bus_write(2'b01, 32'hABCD_EF42);
        wait_cycles(100);
        check("two_bytes_starts", 32'(start_cnt), 32'd2);
        check("two_bytes_single_pulse", 32'(dbl_pulse), 32'd0);
        if (tx_log.size() >= 2) begin
            check("two_bytes_first",  32'(tx_log[0]), 32'h41);
            check("two_bytes_second", 32'(tx_log[1]), 32'h42);
        end else begin
            check("two_bytes_log_size", 32'(tx_log.size()), 32'd2);
        end
        bus_read(2'b11);
        check("two_bytes_status_empty", bus.Read_Data_o, 32'h0000_0002);

        // Busy stuck high: one byte launched, four fill the FIFO, sixth is dropped.
        tx_mode = 1;
        cyc();
        n0 = tx_log.size();
        for (int i = 1; i <= 5; i++) bus_write(2'b01, 32'(i));
        wait_cycles(3);
        bus_read(2'b11);
        check("fill_status_full", bus.Read_Data_o, 32'h0000_040C);
        bus_write(2'b01, 32'h0000_0006);
        bus_read(2'b11);
        check("fill_status_drop", bus.Read_Data_o, 32'h0000_044C);
        check("fill_starts", 32'(tx_log.size()), 32'(n0 + 1));
        if (tx_log.size() > n0) check("fill_first_byte", 32'(tx_log[n0]), 32'h01);

        // Flush and clear, then release the transmitter.
        bus_write(2'b11, 32'h3);
        tx_mode = 2;
        wait_cycles(3);

        // Busy never rises: timeout sets tx_drop, controller returns to idle.
        bus_write(2'b11, 32'h4);
        n0 = tx_log.size();
        bus_write(2'b01, 32'h0000_0077);
        wait_cycles(40);
        check("timeout_starts", 32'(tx_log.size()), 32'(n0 + 1));
        if (tx_log.size() > n0) check("timeout_byte", 32'(tx_log[n0]), 32'h77);
        bus_read(2'b11);
        check("timeout_status", bus.Read_Data_o, 32'h0000_00C2);
        check("timeout_irq", 32'(bus.Irq_o), 32'd1);

        // Flush while a byte is in flight: in-flight byte completes, queue is discarded.
        bus_write(2'b11, 32'h6);
        tx_mode = 1;
        cyc();
        n0 = tx_log.size();
        bus_write(2'b01, 32'h0000_00AA);
        bus_write(2'b01, 32'h0000_00BB);
        bus_write(2'b01, 32'h0000_00CC);
        wait_cycles(10);
        bus_write(2'b11, 32'h5);
        bus_read(2'b11);
        check("flush_status_busy", bus.Read_Data_o, 32'h0000_008A);
        check("flush_irq_low", 32'(bus.Irq_o), 32'd0);
        tx_mode = 2;
        wait_cycles(10);
        bus_read(2'b11);
        check("flush_status_idle", bus.Read_Data_o, 32'h0000_0082);
        check("flush_irq_high", 32'(bus.Irq_o), 32'd1);
        check("flush_starts", 32'(tx_log.size()), 32'(n0 + 1));
        if (tx_log.size() > n0) check("flush_byte", 32'(tx_log[n0]), 32'hAA);

        // Reset during WAIT_LO with three bytes queued.
        tx_mode = 1;
        cyc();
        n0 = tx_log.size();
        for (int i = 0; i < 4; i++) bus_write(2'b01, 32'(8'hD0 + i));
        wait_cycles(8);
        rst = 1'b1;
        cyc();
        check("midrst_read_data", bus.Read_Data_o, 32'h0);
        check("midrst_tx_data",   32'(bus.Tx_Data_o), 32'h0);
        check("midrst_tx_start",  32'(bus.Tx_Start_o), 32'h0);
        check("midrst_irq",       32'(bus.Irq_o), 32'h0);
        rst = 1'b0;
        wait_cycles(30);
        check("midrst_starts", 32'(tx_log.size()), 32'(n0 + 1));
        bus_read(2'b11);
        check("midrst_status", bus.Read_Data_o, 32'h0000_0002);
        bus_write(2'b11, 32'h4);
        check("irq_lag", 32'(bus.Irq_o), 32'd0);
        cyc();
        check("irq_after_enable", 32'(bus.Irq_o), 32'd1);
        check("no_double_pulse", 32'(dbl_pulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
